// File: rtl/wb_regfile_stage.sv
// Writeback stage: commits EX results to the integer register file, retires instructions,
// and provides two combinational write-first read ports plus a one-cycle commit trace.
module wb_regfile_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 64,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ex_valid,
    input  logic             ex_wr_en,
    input  logic [AW-1:0]    ex_wr_addr,
    input  logic [XLEN-1:0]  ex_result,
    input  logic [31:0]      ex_pc,
    input  logic             flush,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic             commit_valid,
    output logic             commit_wr,
    output logic [AW-1:0]    commit_addr,
    output logic [XLEN-1:0]  commit_data,
    output logic [31:0]      commit_pc,
    output logic [CNT_W-1:0] instret
);

    logic            ret;
    logic            we;
    logic [XLEN-1:0] regs [NREGS];

    // Flush squashes the entry outright; x0 is hardwired, so its writes are dropped here.
    assign ret = ex_valid & ~flush;
    assign we  = ret & ex_wr_en & (ex_wr_addr != '0);

    // NOTE: the register array is reset in full because reset must architecturally zero every
    // register; that rules out a RAM macro and keeps the array as flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples
            // pre-edge values regardless of process ordering.
            regs[ex_wr_addr] <= ex_result;
        end
    end

    // NOTE: each read output gets a default first, so no path through the block leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        rs1_data = '0;
        if (rs1_addr != '0) begin
            if (we && (rs1_addr == ex_wr_addr)) begin
                rs1_data = ex_result;
            end else begin
                rs1_data = regs[rs1_addr];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr != '0) begin
            if (we && (rs2_addr == ex_wr_addr)) begin
                rs2_data = ex_result;
            end else begin
                rs2_data = regs[rs2_addr];
            end
        end
    end

    // Counter wraps silently at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instret <= '0;
        end else if (ret) begin
            instret <= instret + CNT_W'(1);
        end
    end

    // Trace payload is only refreshed on a retire, so idle cycles hold the last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            commit_valid <= 1'b0;
            commit_wr    <= 1'b0;
            commit_addr  <= '0;
            commit_data  <= '0;
            commit_pc    <= '0;
        end else begin
            commit_valid <= ret;
            commit_wr    <= we;
            if (ret) begin
                commit_addr <= ex_wr_addr;
                commit_data <= ex_result;
                commit_pc   <= ex_pc;
            end
        end
    end

endmodule

// File: doc/wb_regfile_stage.md
Name: wb_regfile_stage

Overview:
- Writeback end of the EX→WB interface: consumes the execute stage's result, commits it to the architectural integer register file and retires the instruction.
- Provides the two combinational register read ports used by decode, with write-first bypass.
- Maintains a retired-instruction counter and a one-cycle-delayed commit trace for the bench and debug.

Parameters:
XLEN, 32, datapath and register width
NREGS, 32, number of architectural registers (address width = log2(NREGS) = 5)
CNT_W, 64, width of retired-instruction counter

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous, active-low reset
ex_valid  input  1  EX_WB result ready (alu_result_ready)
ex_wr_en  input  1  EX_WB register write enable
ex_wr_addr  input  5  EX_WB destination register
ex_result  input  XLEN  EX_WB alu_result
ex_pc  input  32  EX_WB pc
flush  input  1  squash the EX_WB entry presented this cycle
rs1_addr  input  5  read port 1 address
rs2_addr  input  5  read port 2 address
rs1_data  output  XLEN  read port 1 data, combinational
rs2_data  output  XLEN  read port 2 data, combinational
commit_valid  output  1  registered: an instruction retired last cycle
commit_wr  output  1  registered: that instruction wrote a register
commit_addr  output  5  registered destination
commit_data  output  XLEN  registered written value
commit_pc  output  32  registered retired pc
instret  output  CNT_W  retired-instruction count

Behaviour:
- Reset: clk and reset_n as above; reset is asynchronous, active-low. All NREGS registers = 0, instret = 0, all commit_* = 0. Reset asserted mid-stream discards any in-flight commit; the first post-reset cycle has commit_valid = 0.
- Retire condition: ret = ex_valid & ~flush.
- Write condition: we = ret & ex_wr_en & (ex_wr_addr != 0). On posedge, if we: regs[ex_wr_addr] <= ex_result.
- x0: never written (writes with addr 0 are dropped); any read of addr 0 returns 0.
- Read ports, combinational, for each port p:
  - if rsp_addr == 0 → 0
  - else if we and rsp_addr == ex_wr_addr → ex_result (write-first bypass, same cycle)
  - else → regs[rsp_addr]
- Both ports may read the same address, including the one being written; both return the bypassed value.
- instret: += 1 on every posedge with ret, regardless of ex_wr_en. Wraps from all-ones to 0 with no flag.
- Commit trace, 1-cycle latency, updated every posedge:
  - commit_valid <= ret
  - commit_wr <= we
  - commit_addr <= ex_wr_addr
  - commit_data <= ex_result
  - commit_pc <= ex_pc
  - When ret = 0: commit_wr <= 0; addr, data and pc are don't-care but are held (not updated).
- Flush has priority over ex_valid: no register write, no count, commit_valid = 0 next cycle.
- ex_valid = 0 with ex_wr_en = 1: no write (an invalid slot never writes).
- Back-to-back writes to the same register: the later one wins. A read in the cycle of the second write returns the second value via bypass.
- No backpressure: the stage accepts one entry every cycle.

Test Plan:
- Reset, then read all 32 addresses → every read = 0, instret = 0, commit_valid = 0.
- ex_valid = 1, wr_en = 1, addr = 5, result = 0x1234_5678, rs1_addr = 5 in the same cycle → rs1_data = 0x1234_5678 combinationally. Next cycle: commit_valid = 1, commit_addr = 5, commit_data = 0x1234_5678, instret = 1, and regs[5] reads 0x1234_5678 without bypass.
- Write addr = 0, result = 0xDEAD_BEEF, rs1_addr = rs2_addr = 0 → both reads 0 the same cycle and after; instret increments; commit_wr = 0, commit_valid = 1.
- ex_valid = 1 with flush = 1, addr = 7, result = 0xFF → regs[7] unchanged, instret unchanged, commit_valid = 0 next cycle.
- Preload instret to 2^64 − 1 via 2^64 − 1 retires (or force) → one more retire gives instret = 0.
- Consecutive cycles write x3 = 1 then x3 = 2 with rs2_addr = 3 → rs2_data = 1, then 2. Assert reset_n low mid-sequence → x3 reads 0 immediately after, and commit_valid = 0.
